sram_responder: RTL and testbench
=================================

Name: sram_responder

Overview:
- Synthesizable responder for the external async-SRAM pin interface: the device side of the 128K x16 SRAM bus that the core's SRAM controller drives.
- Decodes addr / we_n / oe_n / ub_n / lb_n each clock and services the access from internal block RAM.
- Lets the core run, and be verified, on targets and benches with no physical SRAM fitted.
- Sits at the top level in place of the SRAM pads; the controller-side tristate is split into separate in, out and output-enable signals.

Parameters:
- AW, 17: width of the sram_addr input.
- DEPTH_LOG2, 17: log2 of backing memory depth in 16-bit words; must be <= AW; higher address bits are ignored, so addresses wrap modulo 2^DEPTH_LOG2.
- READ_LAT, 1: read latency in clocks, legal range 1..4; any other value is an elaboration error.
- CLEAR_VALUE, 16'h0000: word written by the clear sweep (optional feature only).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- sram_addr  in  AW  word address from controller
- sram_dq_i  in  16  write data from controller
- sram_dq_o  out  16  read data to controller
- sram_dq_oe  out  1  high = responder drives dq
- sram_oe_n  in  1  output enable, active low
- sram_we_n  in  1  write enable, active low
- sram_ub_n  in  1  upper byte lane [15:8] enable, active low
- sram_lb_n  in  1  lower byte lane [7:0] enable, active low
- ready  out  1  high = responder servicing bus
- contention  out  1  sticky: we_n and oe_n were both low in the same cycle

Behaviour:
- Reset values: sram_dq_o = 0, sram_dq_oe = 0, contention = 0, read pipeline valids cleared, ready = 0.
- FSM states:
  - INIT: entered on reset.
  - RUN: reached when INIT completes; without the optional feature, INIT lasts exactly 1 cycle, so ready rises on the first edge after reset deasserts.
  - RUN is left only by reset. Memory contents are preserved across reset unless the optional feature is enabled.
- In INIT all bus inputs are ignored: no writes, no reads, sram_dq_oe = 0.
- Write: any RUN cycle sampling we_n = 0.
  - Lanes: lb_n = 0 writes mem[addr][7:0] from dq_i[7:0]; ub_n = 0 writes [15:8] from dq_i[15:8].
  - Both lane enables high means no memory change.
  - One write per cycle; back-to-back writes to different addresses on consecutive cycles must all land.
- Read: any RUN cycle N sampling oe_n = 0 and we_n = 1.
  - At edge N+READ_LAT: sram_dq_o = mem[addr] with disabled lanes forced to 8'h00, and sram_dq_oe = 1.
  - Fully pipelined: one read issued per cycle.
- Non-read slot (oe_n high, or a write): sram_dq_oe = 0 at that slot's output edge; sram_dq_o holds its last value.
- Ordering: a write at cycle N is visible to a read sampled at cycle N+1 or later (write-first). No stale data is allowed for any READ_LAT.
- Contention: a cycle with we_n = 0 and oe_n = 0 performs the write and issues no read. contention sets on the next edge and stays set until reset.
- Reset mid-operation: in-flight reads are discarded (no dq_oe pulse afterward). A write sampled in the reset cycle is dropped.
- X/Z on addr or dq_i when we_n = 1 and oe_n = 1 has no effect.

Optional Feature:
- Macro: SRAM_RESPONDER_CLEAR_EN.
- Defined:
  - INIT runs a sweep writing CLEAR_VALUE to addresses 0..2^DEPTH_LOG2-1, one per cycle.
  - ready rises on the edge after the last address is written, i.e. 2^DEPTH_LOG2 cycles after reset deasserts.
  - Reset during the sweep restarts it at address 0.
- Undefined: no sweep counter is built; INIT is 1 cycle; memory is uninitialised at power-up and untouched by reset.

Test Plan:
- Byte-lane write and masked read: reset; write addr 17'h00010, data 16'hA55A, ub_n = 0, lb_n = 0; then write 16'hFFFF with ub_n = 1, lb_n = 0; read addr 17'h00010 -> dq_o = 16'hA5FF with dq_oe = 1 exactly READ_LAT cycles after the read cycle.
- Read-after-write at READ_LAT = 3: write 16'h1234 to addr 5 in cycle N; read addr 5 in cycle N+1 -> dq_o = 16'h1234 at edge N+4. Write 16'h0001 to addr 5 in cycle N+1 instead; read it in N+2 -> 16'h0001.
- Pipelined reads: fill addrs 0..7 with value = addr*16'h0101; read addrs 0..7 back-to-back -> dq_oe high for 8 consecutive cycles with values 16'h0000..16'h0707 in order. An idle cycle (oe_n = 1) mid-stream produces a single dq_oe = 0 gap.
- Contention and wrap, with DEPTH_LOG2 = 10: we_n = 0, oe_n = 0, addr 17'h00403, data 16'hBEEF -> contention = 1 and sticky, no dq_oe. Read addr 3 -> 16'hBEEF. Reset -> contention = 0.
- Reset mid-read at READ_LAT = 4: issue reads at 2 cycles, assert reset one cycle -> dq_oe never pulses for them. With CLEAR_EN and DEPTH_LOG2 = 4: ready rises 16 cycles after reset; every read returns CLEAR_VALUE.

Source files
------------

// File: rtl/sram_responder.sv
// Device-side responder for the 128K x16 async-SRAM bus, backed by block RAM with a pipelined read path.
// Define SRAM_RESPONDER_CLEAR_EN to sweep CLEAR_VALUE through the memory while in INIT.
module sram_responder #(
   parameter int          AW          = 17,
   parameter int          DEPTH_LOG2  = 17,
   parameter int          READ_LAT    = 1,
   parameter logic [15:0] CLEAR_VALUE = 16'h0000
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] sram_addr,
   input  logic [15:0]   sram_dq_i,
   output logic [15:0]   sram_dq_o,
   output logic          sram_dq_oe,
   input  logic          sram_oe_n,
   input  logic          sram_we_n,
   input  logic          sram_ub_n,
   input  logic          sram_lb_n,
   output logic          ready,
   output logic          contention
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_lat
      $error("sram_responder: READ_LAT must be within 1..4");
   end
   if (DEPTH_LOG2 > AW) begin : g_bad_depth
      $error("sram_responder: DEPTH_LOG2 must not exceed AW");
   end
   if (DEPTH_LOG2 < AW) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^sram_addr[AW-1:DEPTH_LOG2];
   end

   typedef enum logic {S_INIT, S_RUN} state_e;

   state_e state_q, state_d;

   logic                  run;
   logic                  wr_bus;
   logic                  rd_issue;
   logic [DEPTH_LOG2-1:0] bus_idx;
   logic [DEPTH_LOG2-1:0] mem_waddr;
   logic [15:0]           mem_wdata;
   logic                  mem_we_lo, mem_we_hi;
   logic [15:0]           rd_raw, rd_word;
   logic                  contention_q;
   logic                  rd_vld_q [READ_LAT];
   logic [15:0]           rd_dat_q [READ_LAT];
   logic [15:0]           mem      [DEPTH];

   // A cycle sampled while reset is high is dropped even if the FSM still shows RUN.
   assign run      = (state_q == S_RUN) && !reset;
   assign wr_bus   = run && !sram_we_n;
   assign rd_issue = run && !sram_oe_n && sram_we_n;
   assign bus_idx  = sram_addr[DEPTH_LOG2-1:0];

   // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_INIT;
      else       state_q <= state_d;
   end

`ifdef SRAM_RESPONDER_CLEAR_EN
   logic [DEPTH_LOG2-1:0] sweep_q, sweep_d;
   logic                  clr_we;

   always_ff @(posedge clk) begin
      if (reset) sweep_q <= '0;
      else       sweep_q <= sweep_d;
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      sweep_d = sweep_q;
      clr_we  = 1'b0;
      case (state_q)
         S_INIT: begin
            clr_we = !reset;
            if (sweep_q == '1) state_d = S_RUN;
            else               sweep_d = sweep_q + 1'b1;
         end
         S_RUN: state_d = S_RUN;
      endcase
   end
`else
   logic [15:0] unused_clear_value;
   assign unused_clear_value = CLEAR_VALUE;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_INIT: state_d = S_RUN;
         S_RUN:  state_d = S_RUN;
      endcase
   end
`endif

   always_comb begin
      mem_waddr = bus_idx;
      mem_wdata = sram_dq_i;
      mem_we_lo = wr_bus && !sram_lb_n;
      mem_we_hi = wr_bus && !sram_ub_n;
`ifdef SRAM_RESPONDER_CLEAR_EN
      if (clr_we) begin
         mem_waddr = sweep_q;
         mem_wdata = CLEAR_VALUE;
         mem_we_lo = 1'b1;
         mem_we_hi = 1'b1;
      end
`endif
   end

   // NOTE: the memory array has no reset; its contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (mem_we_lo) mem[mem_waddr][7:0]  <= mem_wdata[7:0];
      if (mem_we_hi) mem[mem_waddr][15:8] <= mem_wdata[15:8];
   end

   // Reads sample the array after the previous edge's write, giving write-first ordering.
   assign rd_raw  = mem[bus_idx];
   assign rd_word = {sram_ub_n ? 8'h00 : rd_raw[15:8],
                     sram_lb_n ? 8'h00 : rd_raw[7:0]};

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < READ_LAT; i++) begin
            rd_vld_q[i] <= 1'b0;
            rd_dat_q[i] <= '0;
         end
      end else begin
         rd_vld_q[0] <= rd_issue;
         if (rd_issue) rd_dat_q[0] <= rd_word;
         // Data only advances behind a valid, so the last stage holds between reads.
         for (int i = 1; i < READ_LAT; i++) begin
            rd_vld_q[i] <= rd_vld_q[i-1];
            if (rd_vld_q[i-1]) rd_dat_q[i] <= rd_dat_q[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset)                                 contention_q <= 1'b0;
      else if (run && !sram_we_n && !sram_oe_n) contention_q <= 1'b1;
   end

   assign sram_dq_oe = rd_vld_q[READ_LAT-1];
   assign sram_dq_o  = rd_dat_q[READ_LAT-1];
   assign ready      = (state_q == S_RUN);
   assign contention = contention_q;

endmodule

// File: tb/tb_sram_responder.sv
// Randomized self-checking bench for sram_responder against a cycle-indexed behavioural model.
// Honours SRAM_RESPONDER_CLEAR_EN for ready timing and initial memory contents.
module tb_sram_responder;

   localparam int          AW    = 17;
   localparam int          DL2   = 10;
   localparam int          LAT   = 3;
   localparam int          DEPTH = 1 << DL2;
   localparam logic [15:0] CLR   = 16'hC1EA;
`ifdef SRAM_RESPONDER_CLEAR_EN
   localparam bit CLEAR_ON = 1'b1;
   localparam int EXP_RDY  = DEPTH;
`else
   localparam bit CLEAR_ON = 1'b0;
   localparam int EXP_RDY  = 1;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] sram_addr;
   logic [15:0]   sram_dq_i;
   logic [15:0]   sram_dq_o;
   logic          sram_dq_oe;
   logic          sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
   logic          ready, contention;

   sram_responder #(
      .AW(AW), .DEPTH_LOG2(DL2), .READ_LAT(LAT), .CLEAR_VALUE(CLR)
   ) dut (
      .clk(clk), .reset(reset), .sram_addr(sram_addr), .sram_dq_i(sram_dq_i),
      .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe), .sram_oe_n(sram_oe_n),
      .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n),
      .ready(ready), .contention(contention)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   // Model: memory with per-bit knowledge, and one result slot per sampled cycle.
   bit          m_run;
   int          m_sweep;
   bit          m_cont;
   logic [15:0] m_mem   [DEPTH];
   bit   [15:0] m_known [DEPTH];
   bit          slot_v  [int];
   logic [15:0] slot_d  [int];
   logic [15:0] slot_c  [int];
   int          cyc_n    = 0;
   int          last_rst = 0;
   bit          exp_oe;
   logic [15:0] exp_dq, exp_care;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc_n, got, exp);
      end
   endtask

   task automatic model_edge(input bit r, input bit we, input bit oe, input bit ub, input bit lb,
                             input logic [AW-1:0] a, input logic [15:0] d);
      int          idx;
      int          j;
      logic [15:0] lm;
      cyc_n++;
      slot_v[cyc_n] = 1'b0;
      if (r) begin
         m_run    = 1'b0;
         m_sweep  = 0;
         m_cont   = 1'b0;
         last_rst = cyc_n;
      end else if (!m_run) begin
         if (CLEAR_ON) begin
            m_mem[m_sweep]   = CLR;
            m_known[m_sweep] = '1;
            m_sweep++;
            if (m_sweep == DEPTH) m_run = 1'b1;
         end else begin
            m_run = 1'b1;
         end
      end else if (!we) begin
         idx = int'(a[DL2-1:0]);
         if (!lb) begin m_mem[idx][7:0]  = d[7:0];  m_known[idx][7:0]  = 8'hFF; end
         if (!ub) begin m_mem[idx][15:8] = d[15:8]; m_known[idx][15:8] = 8'hFF; end
         if (!oe) m_cont = 1'b1;
      end else if (!oe) begin
         idx = int'(a[DL2-1:0]);
         lm  = {ub ? 8'h00 : 8'hFF, lb ? 8'h00 : 8'hFF};
         slot_v[cyc_n] = 1'b1;
         slot_d[cyc_n] = m_mem[idx] & lm;
         slot_c[cyc_n] = (m_known[idx] & lm) | ~lm;
      end
      j = cyc_n - LAT + 1;
      if (r) begin
         exp_oe = 1'b0; exp_dq = '0; exp_care = '1;
      end else if (j > last_rst && slot_v.exists(j) && slot_v[j]) begin
         exp_oe = 1'b1; exp_dq = slot_d[j]; exp_care = slot_c[j];
      end else begin
         exp_oe = 1'b0;
      end
   endtask

   task automatic step(input bit r, input bit we, input bit oe, input bit ub, input bit lb,
                       input logic [AW-1:0] a, input logic [15:0] d);
      @(negedge clk);
      reset = r; sram_we_n = we; sram_oe_n = oe; sram_ub_n = ub; sram_lb_n = lb;
      sram_addr = a; sram_dq_i = d;
      @(posedge clk);
      model_edge(r, we, oe, ub, lb, a, d);
      #1;
      check("dq_oe",      {15'd0, sram_dq_oe}, {15'd0, exp_oe});
      check("ready",      {15'd0, ready},      {15'd0, m_run});
      check("contention", {15'd0, contention}, {15'd0, m_cont});
      check("dq_o",       sram_dq_o & exp_care, exp_dq & exp_care);
   endtask

   task automatic idle();
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 'x, 'x);
   endtask
   task automatic wr(input logic [AW-1:0] a, input logic [15:0] d, input bit ub, input bit lb);
      step(1'b0, 1'b0, 1'b1, ub, lb, a, d);
   endtask
   task automatic rd(input logic [AW-1:0] a);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, a, 16'h0000);
   endtask
   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, '0, '0);
   endtask
   task automatic wait_ready();
      int cnt = 0;
      while (!ready && cnt < EXP_RDY + 8) begin
         idle();
         cnt++;
      end
      check("ready_lat", 16'(cnt), 16'(EXP_RDY));
   endtask

   initial begin
      int op;
      logic [AW-1:0] a;

      do_reset(2);
      check("rst_oe", {15'd0, sram_dq_oe}, 16'd0);
      check("rst_dq", sram_dq_o, 16'h0000);
      wait_ready();

      // Byte lanes
      wr(17'h00010, 16'hA55A, 1'b0, 1'b0);
      wr(17'h00010, 16'hFFFF, 1'b1, 1'b0);
      rd(17'h00010);
      for (int i = 0; i < LAT - 1; i++) idle();
      check("lane_rd", sram_dq_o, 16'hA5FF);
      check("lane_oe", {15'd0, sram_dq_oe}, 16'd1);
      idle();
      check("lane_gap", {15'd0, sram_dq_oe}, 16'd0);
      check("lane_hold", sram_dq_o, 16'hA5FF);

      // Read-after-write
      wr(17'd5, 16'h1234, 1'b0, 1'b0);
      rd(17'd5);
      for (int i = 0; i < LAT - 1; i++) idle();
      check("raw_1", sram_dq_o, 16'h1234);
      wr(17'd5, 16'h0001, 1'b0, 1'b0);
      rd(17'd5);
      for (int i = 0; i < LAT - 1; i++) idle();
      check("raw_2", sram_dq_o, 16'h0001);

      // Pipelined reads with one idle gap
      for (int i = 0; i < 8; i++) wr(AW'(i), 16'(i) * 16'h0101, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) rd(AW'(i));
      idle();
      for (int i = 4; i < 8; i++) rd(AW'(i));
      for (int i = 0; i < LAT; i++) idle();

      // Contention and address wrap
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 17'h00403, 16'hBEEF);
      check("cont_set", {15'd0, contention}, 16'd1);
      check("cont_no_oe", {15'd0, sram_dq_oe}, 16'd0);
      idle();
      check("cont_sticky", {15'd0, contention}, 16'd1);
      rd(17'd3);
      for (int i = 0; i < LAT - 1; i++) idle();
      check("wrap_rd", sram_dq_o, 16'hBEEF);
      do_reset(1);
      check("cont_clr", {15'd0, contention}, 16'd0);
      wait_ready();

      // Reset mid-read; a write in the reset cycle is dropped
      wr(17'h00020, 16'h5A5A, 1'b0, 1'b0);
      rd(17'h00020);
      rd(17'd5);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 17'h00020, 16'h0000);
      wait_ready();
      rd(17'h00020);
      for (int i = 0; i < LAT - 1; i++) idle();
      check("rst_wr_drop", sram_dq_o, CLEAR_ON ? CLR : 16'h5A5A);

      // Random traffic
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(0, 299) == 0) begin
            do_reset(1);
            continue;
         end
         op = int'($urandom_range(0, 7));
         a  = AW'($urandom_range(0, 31));
         if ($urandom_range(0, 3) == 0) a = a | (AW'($urandom_range(1, 127)) << DL2);
         case (op)
            0, 1, 2: wr(a, 16'($urandom), 1'($urandom), 1'($urandom));
            3, 4, 5: step(1'b0, 1'b1, 1'b0, 1'($urandom), 1'($urandom), a, 16'h0000);
            6:       idle();
            default: step(1'b0, 1'b0, 1'b0, 1'($urandom), 1'($urandom), a, 16'($urandom));
         endcase
      end
      for (int i = 0; i < LAT; i++) idle();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
